rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter BASE_ADDR, 32'h0010_0000, byte base of the shared memory window; aligned to window size.
REQ-002 Parameter DEPTH, 256, memory depth in 32-bit words (power of two); window size = DEPTH*4 bytes.
REQ-003 clk_i  input  1  clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 instr_req_i  input  1  instruction-port request; held until granted.
REQ-006 instr_gnt_o  output  1  instruction-port grant, same cycle as request.
REQ-007 instr_addr_i  input  32  instruction-port byte address.
REQ-008 instr_rvalid_o  output  1  instruction-port response valid.
REQ-009 instr_rdata_o  output  32  instruction-port read data.
REQ-010 instr_err_o  output  1  instruction-port error, qualified by instr_rvalid_o.
REQ-011 data_req_i  input  1  data-port request; held until granted.
REQ-012 data_gnt_o  output  1  data-port grant.
REQ-013 data_we_i  input  1  data-port write enable.
REQ-014 data_be_i  input  4  data-port byte enables.
REQ-015 data_addr_i  input  32  data-port byte address.
REQ-016 data_wdata_i  input  32  data-port write data.
REQ-017 data_rvalid_o  output  1  data-port response valid.
REQ-018 data_rdata_o  output  32  data-port read data.
REQ-019 data_err_o  output  1  data-port error, qualified by data_rvalid_o.
REQ-020 mem_req_o  output  1  memory access strobe.
REQ-021 mem_we_o  output  1  memory write enable.
REQ-022 mem_be_o  output  4  memory byte enables.
REQ-023 mem_addr_o  output  32  memory byte address.
REQ-024 mem_wdata_o  output  32  memory write data.
REQ-025 mem_rdata_i  input  32  memory read data, valid one cycle after mem_req_o.

Function
REQ-026 At most one grant per cycle; a lone requester is granted combinationally in its request cycle.
REQ-027 Both requesting: grant the port not granted most recently (round-robin); last-grant pointer updates only on a grant.
REQ-028 In-range iff addr[31:log2(DEPTH)+2] == BASE_ADDR[31:log2(DEPTH)+2]; addr[1:0] ignored.
REQ-029 Granted in-range: mem_req_o=1; mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o from winner; instruction port drives we=0, be=4'hF, wdata=0.
REQ-030 Granted out-of-range: still granted, mem_req_o=0, response err=1, rdata=32'h0.
REQ-031 No grant: mem_req_o=0, all other mem_* outputs 0.
REQ-032 Response latency exactly 1 cycle after grant, on granted port only; rdata=mem_rdata_i, err=0 for in-range.
REQ-033 Writes also return rvalid (err per REQ-030); rdata on writes is unspecified.
REQ-034 Fully pipelined: grant possible every cycle while a response is returning; one-entry response register (valid, port, err).
REQ-035 Never both rvalid outputs in the same cycle; no response without a preceding grant.

Reset
REQ-036 Reset: response register cleared, last-grant = instruction (data port wins the first conflict); all rvalid/err outputs 0, rdata outputs 0.
REQ-037 Reset asserted with response pending: response discarded, no rvalid after release.

Structure
REQ-038 Port-select enum (PORT_INSTR, PORT_DATA) and response-record typedef in shared package rom_arb_pkg.
REQ-039 One sub-module: rom_arb_rr2, two-requester round-robin arbiter with last-grant state; range check and response register in top.

Verification
REQ-040 instr_req only, addr=BASE_ADDR+8 -> same-cycle gnt, mem_addr_o=BASE_ADDR+8, next cycle instr_rvalid_o=1, err=0, rdata=mem word 2.
REQ-041 Both request continuously after reset, 4 cycles -> grants D,I,D,I; responses on matching ports one cycle later.
REQ-042 data write addr=BASE_ADDR+4, be=4'h3, wdata=32'hA5A5_1234 -> mem_we_o=1, mem_be_o=4'h3; instr read same word later returns 16'h1234 in low half.
REQ-043 data read addr=BASE_ADDR+DEPTH*4 -> gnt, mem_req_o=0, next cycle data_rvalid_o=1, data_err_o=1, rdata=0.
REQ-044 rst_ni low the cycle after a grant -> no rvalid on either port after release; next conflict granted to data port.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: port select, response record and
// the address-window helper used by the top level.
package rom_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
    } rsp_t;

    localparam rsp_t RSP_IDLE = '{valid: 1'b0, port: PORT_INSTR, err: 1'b0};

    // Compares only the bits above the window offset; aw = log2(window bytes).
    function automatic logic in_window(logic [31:0] addr, logic [31:0] base, int unsigned aw);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << aw;
        return ((addr ^ base) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port of rom_port_arbiter.
// Handshake: a port holds req until gnt is seen in the same cycle; exactly one
// rvalid pulse follows each grant one cycle later, err qualified by rvalid.
interface rom_port_arbiter_if;
    import rom_arb_pkg::*;

    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    port_e       arb_last_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output arb_last_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  arb_last_o
    );

endinterface

// File: rtl/rom_arb_rr2.sv
// Two-requester round-robin arbiter; last_o exposes the last-grant state.
module rom_arb_rr2
    import rom_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  req_instr_i,
    input  logic  req_data_i,
    output logic  gnt_instr_o,
    output logic  gnt_data_o,
    output port_e last_o
);

    port_e last_q, last_d;

    always_comb begin
        gnt_instr_o = 1'b0;
        gnt_data_o  = 1'b0;
        last_d      = last_q;
        if (req_instr_i && req_data_i) begin
            if (last_q == PORT_INSTR) gnt_data_o = 1'b1;
            else                      gnt_instr_o = 1'b1;
        end else if (req_instr_i) begin
            gnt_instr_o = 1'b1;
        end else if (req_data_i) begin
            gnt_data_o = 1'b1;
        end
        if (gnt_instr_o)     last_d = PORT_INSTR;
        else if (gnt_data_o) last_d = PORT_DATA;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= PORT_INSTR;
        else         last_q <= last_d;
    end

    assign last_o = last_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-ported memory between an instruction and a data port:
// round-robin grant, window range check and a one-entry response register.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    rom_port_arbiter_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH) + 2;

    logic        gnt_instr, gnt_data;
    port_e       last_grant;
    logic [31:0] sel_addr;
    logic        sel_in_range;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    rsp_t        rsp_q, rsp_d;
    logic        instr_rvalid, data_rvalid;

    rom_arb_rr2 u_rr2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_instr_i (bus.instr_req_i),
        .req_data_i  (bus.data_req_i),
        .gnt_instr_o (gnt_instr),
        .gnt_data_o  (gnt_data),
        .last_o      (last_grant)
    );

    always_comb begin
        sel_addr     = gnt_data ? bus.data_addr_i : bus.instr_addr_i;
        sel_in_range = in_window(sel_addr, BASE_ADDR, AW);
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        rsp_d        = RSP_IDLE;
        if (gnt_instr || gnt_data) begin
            rsp_d.valid = 1'b1;
            rsp_d.port  = gnt_data ? PORT_DATA : PORT_INSTR;
            rsp_d.err   = !sel_in_range;
            // Out-of-range grants complete with an error but never touch memory.
            if (sel_in_range) begin
                mem_req  = 1'b1;
                mem_addr = sel_addr;
                if (gnt_data) begin
                    mem_we    = bus.data_we_i;
                    mem_be    = bus.data_be_i;
                    mem_wdata = bus.data_wdata_i;
                end else begin
                    mem_be    = 4'hF;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_q <= RSP_IDLE;
        else         rsp_q <= rsp_d;
    end

    assign instr_rvalid = rsp_q.valid && (rsp_q.port == PORT_INSTR);
    assign data_rvalid  = rsp_q.valid && (rsp_q.port == PORT_DATA);

    assign bus.instr_gnt_o    = gnt_instr;
    assign bus.data_gnt_o     = gnt_data;
    assign bus.mem_req_o      = mem_req;
    assign bus.mem_we_o       = mem_we;
    assign bus.mem_be_o       = mem_be;
    assign bus.mem_addr_o     = mem_addr;
    assign bus.mem_wdata_o    = mem_wdata;
    assign bus.arb_last_o     = last_grant;

    assign bus.instr_rvalid_o = instr_rvalid;
    assign bus.instr_err_o    = instr_rvalid && rsp_q.err;
    assign bus.instr_rdata_o  = (instr_rvalid && !rsp_q.err) ? bus.mem_rdata_i : 32'h0;
    assign bus.data_rvalid_o  = data_rvalid;
    assign bus.data_err_o     = data_rvalid && rsp_q.err;
    assign bus.data_rdata_o   = (data_rvalid && !rsp_q.err) ? bus.mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: per-cycle vector table against a small
// synchronous RAM model, plus a reset-during-response sequence.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    localparam logic [31:0] B = 32'h0010_0000;
    localparam logic [31:0] Z = 32'h0;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(.BASE_ADDR(B), .DEPTH(256)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word i preloaded with C0DE_0000 + i, read data one cycle later.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        bus.mem_rdata_i = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b]) mem[bus.mem_addr_o[9:2]][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
            end else begin
                bus.mem_rdata_i <= mem[bus.mem_addr_o[9:2]];
            end
        end
    end

    typedef struct {
        string       name;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [1:0]  exp_gnt;    // {data, instr}
        logic        exp_mreq;
        logic [31:0] exp_maddr;
        logic        exp_mwe;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_mwdata;
        logic [1:0]  exp_rv;     // {data, instr}
        logic        exp_err;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.instr_req_i  = v.ireq;
        bus.instr_addr_i = v.iaddr;
        bus.data_req_i   = v.dreq;
        bus.data_we_i    = v.dwe;
        bus.data_be_i    = v.dbe;
        bus.data_addr_i  = v.daddr;
        bus.data_wdata_i = v.dwdata;
    endtask

    task automatic drive_idle();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = Z;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'h0;
        bus.data_addr_i  = Z;
        bus.data_wdata_i = Z;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, ".instr_gnt"}, 32'(bus.instr_gnt_o), 32'(v.exp_gnt[0]));
        chk({v.name, ".data_gnt"},  32'(bus.data_gnt_o),  32'(v.exp_gnt[1]));
        chk({v.name, ".mem_req"},   32'(bus.mem_req_o),   32'(v.exp_mreq));
        chk({v.name, ".mem_addr"},  bus.mem_addr_o,       v.exp_maddr);
        chk({v.name, ".mem_we"},    32'(bus.mem_we_o),    32'(v.exp_mwe));
        chk({v.name, ".mem_be"},    32'(bus.mem_be_o),    32'(v.exp_mbe));
        chk({v.name, ".mem_wdata"}, bus.mem_wdata_o,      v.exp_mwdata);
        chk({v.name, ".instr_rvalid"}, 32'(bus.instr_rvalid_o), 32'(v.exp_rv[0]));
        chk({v.name, ".data_rvalid"},  32'(bus.data_rvalid_o),  32'(v.exp_rv[1]));
        if (v.exp_rv[0]) begin
            chk({v.name, ".instr_err"}, 32'(bus.instr_err_o), 32'(v.exp_err));
            if (v.chk_rdata) chk({v.name, ".instr_rdata"}, bus.instr_rdata_o, v.exp_rdata);
        end
        if (v.exp_rv[1]) begin
            chk({v.name, ".data_err"}, 32'(bus.data_err_o), 32'(v.exp_err));
            if (v.chk_rdata) chk({v.name, ".data_rdata"}, bus.data_rdata_o, v.exp_rdata);
        end
    endtask

    initial begin
        //          name         ireq  iaddr          dreq  dwe   dbe   daddr          dwdata          gnt    mreq  maddr          mwe   mbe   mwdata          rv     err   chk   rdata
        vecs[0]  = '{"instr_rd",  1'b1, B + 32'h8,     1'b0, 1'b0, 4'h0, Z,             Z,              2'b01, 1'b1, B + 32'h8,     1'b0, 4'hF, Z,              2'b00, 1'b0, 1'b0, Z};
        vecs[1]  = '{"instr_rsp", 1'b0, Z,             1'b0, 1'b0, 4'h0, Z,             Z,              2'b00, 1'b0, Z,             1'b0, 4'h0, Z,              2'b01, 1'b0, 1'b1, 32'hC0DE_0002};
        vecs[2]  = '{"both_d1",   1'b1, B + 32'h10,    1'b1, 1'b0, 4'hF, B + 32'h14,    Z,              2'b10, 1'b1, B + 32'h14,    1'b0, 4'hF, Z,              2'b00, 1'b0, 1'b0, Z};
        vecs[3]  = '{"both_i1",   1'b1, B + 32'h10,    1'b1, 1'b0, 4'hF, B + 32'h14,    Z,              2'b01, 1'b1, B + 32'h10,    1'b0, 4'hF, Z,              2'b10, 1'b0, 1'b1, 32'hC0DE_0005};
        vecs[4]  = '{"both_d2",   1'b1, B + 32'h10,    1'b1, 1'b0, 4'hF, B + 32'h14,    Z,              2'b10, 1'b1, B + 32'h14,    1'b0, 4'hF, Z,              2'b01, 1'b0, 1'b1, 32'hC0DE_0004};
        vecs[5]  = '{"both_i2",   1'b1, B + 32'h10,    1'b1, 1'b0, 4'hF, B + 32'h14,    Z,              2'b01, 1'b1, B + 32'h10,    1'b0, 4'hF, Z,              2'b10, 1'b0, 1'b1, 32'hC0DE_0005};
        vecs[6]  = '{"both_rsp",  1'b0, Z,             1'b0, 1'b0, 4'h0, Z,             Z,              2'b00, 1'b0, Z,             1'b0, 4'h0, Z,              2'b01, 1'b0, 1'b1, 32'hC0DE_0004};
        vecs[7]  = '{"data_wr",   1'b0, Z,             1'b1, 1'b1, 4'h3, B + 32'h4,     32'hA5A5_1234,  2'b10, 1'b1, B + 32'h4,     1'b1, 4'h3, 32'hA5A5_1234,  2'b00, 1'b0, 1'b0, Z};
        vecs[8]  = '{"instr_rb",  1'b1, B + 32'h4,     1'b0, 1'b0, 4'h0, Z,             Z,              2'b01, 1'b1, B + 32'h4,     1'b0, 4'hF, Z,              2'b10, 1'b0, 1'b0, Z};
        vecs[9]  = '{"data_oor",  1'b0, Z,             1'b1, 1'b0, 4'hF, B + 32'h400,   Z,              2'b10, 1'b0, Z,             1'b0, 4'h0, Z,              2'b01, 1'b0, 1'b1, 32'hC0DE_1234};
        vecs[10] = '{"instr_oor", 1'b1, 32'h8,         1'b0, 1'b0, 4'h0, Z,             Z,              2'b01, 1'b0, Z,             1'b0, 4'h0, Z,              2'b10, 1'b1, 1'b1, Z};
        vecs[11] = '{"instr_top", 1'b1, B + 32'h3FF,   1'b0, 1'b0, 4'h0, Z,             Z,              2'b01, 1'b1, B + 32'h3FF,   1'b0, 4'hF, Z,              2'b01, 1'b1, 1'b1, Z};
        vecs[12] = '{"top_rsp",   1'b0, Z,             1'b0, 1'b0, 4'h0, Z,             Z,              2'b00, 1'b0, Z,             1'b0, 4'h0, Z,              2'b01, 1'b0, 1'b1, 32'hC0DE_00FF};
        vecs[13] = '{"idle",      1'b0, Z,             1'b0, 1'b0, 4'h0, Z,             Z,              2'b00, 1'b0, Z,             1'b0, 4'h0, Z,              2'b00, 1'b0, 1'b0, Z};

        drive_idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        chk("rst.instr_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
        chk("rst.data_rvalid",  32'(bus.data_rvalid_o),  32'h0);
        chk("rst.instr_err",    32'(bus.instr_err_o),    32'h0);
        chk("rst.data_err",     32'(bus.data_err_o),     32'h0);
        chk("rst.instr_rdata",  bus.instr_rdata_o,       Z);
        chk("rst.data_rdata",   bus.data_rdata_o,        Z);
        chk("rst.mem_req",      32'(bus.mem_req_o),      32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i]);
            @(negedge clk);
            n_vec++;
            check_vec(vecs[i]);
        end

        // Grant the data port so the pointer would favour instr, then reset
        // while that response is in flight.
        @(posedge clk);
        #1;
        bus.data_req_i  = 1'b1;
        bus.data_be_i   = 4'hF;
        bus.data_addr_i = B;
        @(negedge clk);
        n_vec++;
        chk("pre_rst.data_gnt", 32'(bus.data_gnt_o), 32'h1);
        @(posedge clk);
        #1;
        drive_idle();
        rst_ni = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("in_rst.data_rvalid",  32'(bus.data_rvalid_o),  32'h0);
        chk("in_rst.instr_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
        chk("in_rst.data_rdata",   bus.data_rdata_o,        Z);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            chk("post_rst.data_rvalid",  32'(bus.data_rvalid_o),  32'h0);
            chk("post_rst.instr_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
            @(posedge clk);
            #1;
        end
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = B + 32'h10;
        bus.data_req_i   = 1'b1;
        bus.data_be_i    = 4'hF;
        bus.data_addr_i  = B + 32'h14;
        @(negedge clk);
        n_vec++;
        chk("post_rst.conflict_data_gnt",  32'(bus.data_gnt_o),  32'h1);
        chk("post_rst.conflict_instr_gnt", 32'(bus.instr_gnt_o), 32'h0);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        n_vec++;
        chk("post_rst.rsp_data_rvalid", 32'(bus.data_rvalid_o), 32'h1);
        chk("post_rst.rsp_data_rdata",  bus.data_rdata_o,       32'hC0DE_0005);
        chk("post_rst.rsp_instr_rvalid", 32'(bus.instr_rvalid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
